// File: rtl/button_pulse_gen.sv
// Push-button conditioner: synchronizes and debounces a raw switch, then
// produces a press pulse on acceptance, auto-repeat pulses while held, and
// a release pulse when the debounced level drops. All outputs are registered.
module button_pulse_gen #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 12500000,
  parameter int REPEAT_LIMIT   = 2500000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Press,
  output logic o_Release,
  output logic o_Repeat_Active
);

  localparam int DB_W    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int TMR_MAX = (HOLD_LIMIT > REPEAT_LIMIT) ? HOLD_LIMIT : REPEAT_LIMIT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_LIMIT - 1);
  localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(REPEAT_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_REPEAT = 2'b10
  } state_t;

  logic             sync1_q;
  logic             sync2_q;
  logic [DB_W-1:0]  db_cnt_q,  db_cnt_d;
  logic             level_q,   level_d;
  logic             toggle_s;
  state_t           state_q,   state_d;
  logic [TMR_W-1:0] timer_q,   timer_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;
  logic             rpt_q,     rpt_d;
  logic             rise_s;
  logic             fall_s;

  // Two-flop synchronizer for the asynchronous switch input.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_Switch;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles the synchronized input disagrees with
  // the accepted level; flip the level when the count completes.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    toggle_s = 1'b0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        toggle_s = 1'b1;
        level_d  = ~level_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  assign rise_s = toggle_s & ~level_q;
  assign fall_s = toggle_s &  level_q;

  // Hold/repeat FSM next-state and pulse decode; release wins over timer expiry.
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d = ST_HOLD;
          press_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (fall_s) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else if (timer_q == HOLD_LAST) begin
          state_d = ST_REPEAT;
          press_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_REPEAT: begin
        if (fall_s) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else if (timer_q == RPT_LAST) begin
          press_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rpt_d = (state_d == ST_REPEAT);
  end

  // Register debounce state, FSM state and every output.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      press_q   <= press_d;
      release_q <= release_d;
      rpt_q     <= rpt_d;
    end
  end

  assign o_Level         = level_q;
  assign o_Press         = press_q;
  assign o_Release       = release_q;
  assign o_Repeat_Active = rpt_q;

endmodule
